// File: rtl/clk_nco_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clk_nco_pkg : shared lock-state type and default accumulator width
// Revision    : 1.0
// ----------------------------------------------------------------------------
package clk_nco_pkg;

  localparam int unsigned c_ACC_W_DEFAULT = 32;

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage : clk_nco_pkg
`default_nettype wire

// File: rtl/clk_enable_nco_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nco_channel : one phase accumulator producing a registered carry strobe
// Revision    : 1.0
// ----------------------------------------------------------------------------
module nco_channel
  import clk_nco_pkg::*;
#(
  parameter int unsigned ACC_W    = c_ACC_W_DEFAULT,
  parameter logic [63:0] INIT_INC = 64'd575525618
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [ACC_W-1:0] i_inc,
  input  logic             i_en,
  output logic             o_clken
);

  logic [ACC_W-1:0] r_inc;
  logic [ACC_W-1:0] r_acc;
  logic             r_clken;
  logic [ACC_W:0]   w_sum;

  // One extra bit captures the wrap of the accumulator as the strobe.
  assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc   <= INIT_INC[ACC_W-1:0];
      r_acc   <= '0;
      r_clken <= 1'b0;
    end else if (i_wr) begin
      r_inc   <= i_inc;
      r_acc   <= '0;
      r_clken <= 1'b0;
    end else if (i_en) begin
      r_acc   <= w_sum[ACC_W-1:0];
      r_clken <= w_sum[ACC_W];
    end else begin
      r_clken <= 1'b0;
    end
  end

  assign o_clken = r_clken;

endmodule : nco_channel
`default_nettype wire

// File: rtl/clk_enable_nco.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clk_enable_nco : multi-channel NCO clock-enable generator with lock flag
// Revision       : 1.0
// ----------------------------------------------------------------------------
module clk_enable_nco
  import clk_nco_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ACC_W       = c_ACC_W_DEFAULT,
  parameter int unsigned LOCK_CYCLES = 256,
  parameter logic [63:0] INIT_INC    = 64'd575525618,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clken,
  output logic              locked
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);

  logic             w_valid_wr;
  lock_state_t      r_state;
  lock_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Out-of-range channel numbers are dropped before they reach anything.
  assign w_valid_wr = cfg_we && ({{(32 - CH_W){1'b0}}, cfg_ch} < NUM_CH);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic w_wr;
      assign w_wr = w_valid_wr && (cfg_ch == CH_W'(i));

      nco_channel #(
        .ACC_W    (ACC_W),
        .INIT_INC (INIT_INC)
      ) u_ch (
        .clk     (refclk),
        .rst_n   (rst_n),
        .i_wr    (w_wr),
        .i_inc   (cfg_inc),
        .i_en    (ch_en[i]),
        .o_clken (clken[i])
      );
    end
  endgenerate

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SETTLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_valid_wr) begin
      w_state_nxt = SETTLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        SETTLE: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
            w_state_nxt = LOCKED;
          end
        end
        LOCKED:  w_state_nxt = LOCKED;
        default: w_state_nxt = SETTLE;
      endcase
    end
  end

  always_comb begin
    locked = 1'b0;
    if (r_state == LOCKED) begin
      locked = 1'b1;
    end
  end

endmodule : clk_enable_nco
`default_nettype wire

// File: tb/tb_clk_enable_nco.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_clk_enable_nco : directed + random checks against an arithmetic model
// Revision          : 1.0
// ----------------------------------------------------------------------------
module tb_clk_enable_nco;

  localparam int              ACC_W = 32;
  localparam int              LOCK  = 256;
  localparam longint unsigned MODV  = 64'd1 << ACC_W;
  localparam longint unsigned INIT  = 64'd575525618;

  logic refclk = 1'b0;
  always #5 refclk = ~refclk;

  logic        rst_n;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [31:0] cfg_inc;
  logic [1:0]  ch_en;
  logic [1:0]  clken;
  logic        locked;

  logic        cfg_we_b;
  logic [1:0]  cfg_ch_b;
  logic [31:0] cfg_inc_b;
  logic [2:0]  ch_en_b;
  logic [2:0]  clken_b;
  logic        locked_b;

  clk_enable_nco dut (
    .refclk (refclk), .rst_n (rst_n), .cfg_we (cfg_we), .cfg_ch (cfg_ch),
    .cfg_inc (cfg_inc), .ch_en (ch_en), .clken (clken), .locked (locked)
  );

  // Second instance: quarter-rate increment and a channel count that leaves
  // an unused cfg_ch code (3) for the out-of-range write check.
  clk_enable_nco #(.NUM_CH(3), .INIT_INC(64'h4000_0000)) dut_b (
    .refclk (refclk), .rst_n (rst_n), .cfg_we (cfg_we_b), .cfg_ch (cfg_ch_b),
    .cfg_inc (cfg_inc_b), .ch_en (ch_en_b), .clken (clken_b), .locked (locked_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  longint unsigned m_acc [2];
  longint unsigned m_inc [2];
  bit              m_p   [2];
  int              m_since;
  int              b_cnt [3];
  bit              b_p   [3];
  int              b_since;
  int              pc    [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    longint unsigned s;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin m_acc[i] = 0; m_inc[i] = INIT; m_p[i] = 0; end
      for (int i = 0; i < 3; i++) begin b_cnt[i] = 0; b_p[i] = 0; end
      m_since = 0;
      b_since = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cfg_we && cfg_ch == i) begin
          m_inc[i] = cfg_inc; m_acc[i] = 0; m_p[i] = 0;
        end else if (ch_en[i]) begin
          s = m_acc[i] + m_inc[i];
          m_p[i]   = (s >= MODV);
          m_acc[i] = s % MODV;
        end else begin
          m_p[i] = 0;
        end
      end
      if (cfg_we) m_since = 0; else if (m_since < LOCK) m_since++;
      for (int i = 0; i < 3; i++) begin
        if (ch_en_b[i]) begin b_cnt[i]++; b_p[i] = (b_cnt[i] % 4 == 0); end
        else b_p[i] = 0;
      end
      if (cfg_we_b && cfg_ch_b < 3) b_since = 0; else if (b_since < LOCK) b_since++;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge refclk);
    model_edge();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("clken%0d", i), clken[i], m_p[i]);
      if (clken[i]) pc[i]++;
    end
    chk("locked", locked, (m_since >= LOCK));
    for (int i = 0; i < 3; i++) chk($sformatf("b_clken%0d", i), clken_b[i], b_p[i]);
    chk("b_locked", locked_b, (b_since >= LOCK));
  endtask

  initial begin
    int found;
    int p0;
    int p1;
    int c0;
    int c1;
    rst_n = 0; cfg_we = 0; cfg_ch = 0; cfg_inc = 0; ch_en = 2'b11;
    cfg_we_b = 0; cfg_ch_b = 0; cfg_inc_b = 0; ch_en_b = 3'b111;
    pc[0] = 0; pc[1] = 0;
    #2;
    chk("reset_clken", clken, 2'b00);
    chk("reset_locked", locked, 0);
    repeat (3) tick();
    rst_n = 1;

    // Quarter-rate pulses and lock timing from reset release
    for (int k = 1; k <= 299; k++) begin
      tick();
      if (k <= 16) chk("quarter_rate", clken_b[0], (k % 4 == 0));
      if (k == 255) chk("lock_early", locked, 0);
      if (k == 256) chk("lock_rise", locked, 1);
    end
    cfg_we = 1; cfg_ch = 0; cfg_inc = 32'(INIT);
    tick();
    cfg_we = 0;
    chk("lock_drop", locked, 0);
    repeat (255) tick();
    chk("relock_early", locked, 0);
    tick();
    chk("relock", locked, 1);

    // Write that collides with a ch1 carry
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_acc[1] + m_inc[1] >= MODV) found = 1; else tick();
    end
    chk("carry_search", found, 1);
    cfg_we = 1; cfg_ch = 1; cfg_inc = 32'h8000_0000;
    tick();
    cfg_we = 0;
    chk("collide_no_pulse", clken[1], 0);
    chk("collide_acc", dut.g_ch[1].u_ch.r_acc, 0);
    tick();
    chk("collide_edge1", clken[1], 0);
    tick();
    chk("collide_edge2", clken[1], 1);

    // Stall ch0 of the second instance for 10 cycles
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      if (clken_b[0]) found = 1;
    end
    chk("stall_sync", found, 1);
    p0 = cyc;
    ch_en_b[0] = 0;
    repeat (10) tick();
    ch_en_b[0] = 1;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (clken_b[0]) found = 1;
    end
    chk("stall_gap", cyc - p0, 14);

    // Out-of-range write must leave the second instance untouched
    cfg_we_b = 1; cfg_ch_b = 2'd3; cfg_inc_b = 32'd1;
    tick();
    cfg_we_b = 0;
    repeat (8) tick();
    chk("bad_ch_locked", locked_b, 1);

    // Random enables and writes
    for (int k = 0; k < 2000; k++) begin
      ch_en   = 2'($urandom);
      ch_en_b = 3'($urandom);
      cfg_we  = ($urandom_range(0, 15) == 0);
      cfg_ch  = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       cfg_inc = 32'd0;
        1:       cfg_inc = 32'hFFFF_FFFF;
        default: cfg_inc = $urandom;
      endcase
      tick();
    end
    cfg_we = 0; ch_en = 2'b11; ch_en_b = 3'b111;

    // Increment extremes
    cfg_we = 1; cfg_ch = 0; cfg_inc = 32'd0;
    tick();
    cfg_ch = 1; cfg_inc = 32'hFFFF_FFFF;
    tick();
    cfg_we = 0;
    p0 = pc[0]; p1 = pc[1];
    repeat (100) tick();
    chk("inc_zero_pulses", pc[0] - p0, 0);
    chk("inc_max_pulses", pc[1] - p1, 99);

    // Long-run average at the reset increment
    cfg_we = 1; cfg_ch = 0; cfg_inc = 32'(INIT);
    tick();
    cfg_ch = 1;
    tick();
    cfg_we = 0;
    p0 = pc[0]; p1 = pc[1];
    repeat (50000) tick();
    c0 = pc[0] - p0;
    c1 = pc[1] - p1;
    chk("rate_ch0", (c0 >= 6699 && c0 <= 6701), 1);
    chk("rate_ch1", (c1 >= 6699 && c1 <= 6701), 1);

    // Asynchronous reset right after a pulse
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      if (clken_b[0]) found = 1;
    end
    chk("pre_reset_pulse", found, 1);
    chk("pre_reset_locked", locked, 1);
    #1 rst_n = 0;
    #1;
    chk("async_clken", clken, 2'b00);
    chk("async_clken_b", clken_b, 3'b000);
    chk("async_locked", locked, 0);
    chk("async_locked_b", locked_b, 0);
    repeat (2) tick();
    rst_n = 1;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_clk_enable_nco
`default_nettype wire
